mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multi-cycle control unit for the MIPS datapath. It decodes the instruction register and drives the ALU control port (alu_op, operand selects) plus the register-file, memory and PC strobes, one state per cycle. It is the producer side of the ALU interface and consumes alu_zero for branch resolution. A single memory port is shared for fetch and data, with a ready handshake for wait states.

Parameters:
- OP_W, 4, width of alu_op. Encodings ALU_ADD/SUB/OR/LUI/ADDIU/NOR come from macro.vh.
- RESET_STATE_IF, 1, reserved and must stay 1: the FSM leaves reset in S_IF.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], stable from S_ID until the next ir_we
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- alu_op  out  4  ALU operation
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- aluout_we  out  1  latch the ALU result into ALUOut
- pc_we  out  1  PC write enable
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}
- ir_we  out  1  IR write enable
- mem_re  out  1  memory read request
- mem_we  out  1  memory write request
- iord  out  1  0 = PC address, 1 = ALUOut address
- reg_we  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- retire  out  1  one-cycle pulse in an instruction's final cycle

Behaviour:
- Outputs are Moore-decoded from a 4-bit state register plus opcode/funct. Every output defaults to 0 in every state unless listed below.
- Reset: state = S_IF. During reset, mem_re = 1, iord = 0, alu_op = ALU_ADD, alu_src_b = 01; all other outputs = 0. pc_we and ir_we stay 0 until mem_ready.
- S_IF:
  - mem_re = 1, alu_src_a = 0, alu_src_b = 01, ALU_ADD.
  - pc_we = ir_we = mem_ready, pc_src = 00.
  - Stays in S_IF while !mem_ready; goes to S_ID on mem_ready.
- S_ID:
  - alu_src_a = 0, alu_src_b = 11, ALU_ADD, aluout_we = 1 (precomputes the branch target).
  - Next state by opcode:
    - 000000 -> S_EX_R
    - 001101 (ori), 001111 (lui), 001001 (addiu) -> S_EX_I
    - 100011 (lw), 101011 (sw) -> S_ADDR
    - 000100 (beq) -> S_BR
    - 000010 (j) -> S_J
    - anything else -> S_IF
  - R-type funct map: 100001 addu / 100000 add -> ALU_ADD; 100011 subu / 100010 sub -> ALU_SUB; 100111 nor -> ALU_NOR. Unknown funct -> S_IF.
- S_EX_R: alu_src_a = 1, alu_src_b = 00, alu_op per funct, aluout_we = 1 -> S_WB_R.
- S_WB_R: reg_we = 1, reg_dst = 1, mem_to_reg = 0, retire = 1 -> S_IF.
- S_EX_I:
  - alu_src_a = 1, alu_src_b = 10, aluout_we = 1.
  - alu_op: ori -> ALU_OR, lui -> ALU_LUI, addiu -> ALU_ADDIU.
  - -> S_WB_I.
- S_WB_I: reg_we = 1, reg_dst = 0, mem_to_reg = 0, retire = 1 -> S_IF.
- S_ADDR: alu_src_a = 1, alu_src_b = 10, ALU_ADD, aluout_we = 1. Goes to S_MRD for lw, S_MWR for sw.
- S_MRD: mem_re = 1, iord = 1. Holds while !mem_ready, then -> S_WB_M.
- S_WB_M: reg_we = 1, reg_dst = 0, mem_to_reg = 1, retire = 1 -> S_IF.
- S_MWR: mem_we = 1, iord = 1. Holds while !mem_ready. On mem_ready: retire = 1 -> S_IF.
- S_BR: alu_src_a = 1, alu_src_b = 00, ALU_SUB, pc_src = 01, pc_we = alu_zero, retire = 1 -> S_IF.
- S_J: pc_src = 10, pc_we = 1, retire = 1 -> S_IF.
- Latency (no wait states): R/I-type 4 cycles, lw 5, sw 4, beq 3, j 3.
- Memory handshake: a request stays asserted with a stable iord until mem_ready. mem_ready outside S_IF/S_MRD/S_MWR is ignored.
- Reset mid-instruction forces S_IF immediately. No partial strobe (reg_we, mem_we, pc_we) may follow the release of reset.
- Unused state encodings recover to S_IF on the next edge.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - Adds output illegal (1 bit, reset 0) and state S_HALT.
  - An unknown opcode or R-type funct in S_ID goes to S_HALT and sets illegal = 1.
  - S_HALT drives every strobe to 0 and holds until rst.
- Undefined: unknown instructions silently go to S_IF (no-op, no retire); the illegal port is absent.

Test Plan:
- Reset release, mem_ready = 1, IR = addu (op 000000, funct 100001) -> states IF, ID, EX_R, WB_R; ALU_ADD in EX_R; reg_we = reg_dst = 1 and retire in cycle 4; back in IF in cycle 5.
- lw with mem_ready low for 3 cycles in S_MRD -> mem_re = iord = 1 held for 4 cycles; reg_we with mem_to_reg = 1 exactly once; 8 cycles total.
- beq with alu_zero = 1 -> pc_we = 1, pc_src = 01 in cycle 3. Repeat with alu_zero = 0 -> pc_we = 0, retire = 1.
- lui -> alu_op = ALU_LUI, alu_src_b = 10 in EX_I; reg_dst = 0 in WB_I. Repeat for ori -> ALU_OR and addiu -> ALU_ADDIU.
- Assert rst during S_MWR with mem_ready = 0 -> mem_we = 0 immediately; after release, state is S_IF with mem_re = 1.
- Opcode 111111 -> without ILLEGAL_TRAP_EN, back to S_IF after ID with no retire. With it defined, illegal = 1 and no strobes until rst.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control FSM; optional ILLEGAL_TRAP_EN adds illegal-instruction halt
module mips_mc_ctrl #(
  parameter int OP_W           = 4,
  parameter int RESET_STATE_IF = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic [OP_W-1:0] alu_op,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            aluout_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            ir_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            iord,
  output logic            reg_we,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            retire
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  // ALU operation encodings shared with the ALU
  localparam logic [OP_W-1:0] ALU_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_OR    = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_LUI   = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_ADDIU = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_NOR   = OP_W'(5);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX_R = 4'd2,
    S_WB_R = 4'd3,
    S_EX_I = 4'd4,
    S_WB_I = 4'd5,
    S_ADDR = 4'd6,
    S_MRD  = 4'd7,
    S_WB_M = 4'd8,
    S_MWR  = 4'd9,
    S_BR   = 4'd10,
    S_J    = 4'd11,
    S_HALT = 4'd12
  } state_t;

  // Fetch is the only legal reset state; the parameter exists for interface compatibility
  localparam state_t RESET_ST = (RESET_STATE_IF != 0) ? S_IF : S_IF;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_BAD = S_HALT;
`else
  localparam state_t S_BAD = S_IF;
`endif

  state_t          state;
  state_t          state_nx;
  logic            funct_ok;
  logic [OP_W-1:0] r_op;
  logic [OP_W-1:0] i_op;

  // R-type funct decode: ALU op and legality
  always_comb begin
    funct_ok = 1'b1;
    r_op     = ALU_ADD;
    case (funct)
      FN_ADDU, FN_ADD: r_op = ALU_ADD;
      FN_SUBU, FN_SUB: r_op = ALU_SUB;
      FN_NOR:          r_op = ALU_NOR;
      default:         funct_ok = 1'b0;
    endcase
  end

  // I-type immediate ALU op from opcode
  always_comb begin
    i_op = ALU_ADDIU;
    case (opcode)
      OP_ORI:  i_op = ALU_OR;
      OP_LUI:  i_op = ALU_LUI;
      default: i_op = ALU_ADDIU;
    endcase
  end

  // State register; reset lands in fetch immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET_ST;
    else     state <= state_nx;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nx   = S_IF;
    alu_op     = '0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluout_we  = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IF: begin
        mem_re    = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        // PC/IR update only on a completed fetch, never while reset is held
        pc_we     = mem_ready & ~rst;
        ir_we     = mem_ready & ~rst;
        state_nx  = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        aluout_we = 1'b1;
        case (opcode)
          OP_RTYPE:                state_nx = funct_ok ? S_EX_R : S_BAD;
          OP_ORI, OP_LUI, OP_ADDIU: state_nx = S_EX_I;
          OP_LW, OP_SW:            state_nx = S_ADDR;
          OP_BEQ:                  state_nx = S_BR;
          OP_J:                    state_nx = S_J;
          default:                 state_nx = S_BAD;
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_op;
        aluout_we = 1'b1;
        state_nx  = S_WB_R;
      end
      S_WB_R: begin
        reg_we   = 1'b1;
        reg_dst  = 1'b1;
        retire   = 1'b1;
        state_nx = S_IF;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = i_op;
        aluout_we = 1'b1;
        state_nx  = S_WB_I;
      end
      S_WB_I: begin
        reg_we   = 1'b1;
        retire   = 1'b1;
        state_nx = S_IF;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        aluout_we = 1'b1;
        state_nx  = (opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_re   = 1'b1;
        iord     = 1'b1;
        state_nx = mem_ready ? S_WB_M : S_MRD;
      end
      S_WB_M: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nx   = S_IF;
      end
      S_MWR: begin
        mem_we   = 1'b1;
        iord     = 1'b1;
        retire   = mem_ready;
        state_nx = mem_ready ? S_IF : S_MWR;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_we     = alu_zero;
        retire    = 1'b1;
        state_nx  = S_IF;
      end
      S_J: begin
        pc_src   = 2'b10;
        pc_we    = 1'b1;
        retire   = 1'b1;
        state_nx = S_IF;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: state_nx = S_HALT;
`endif
      default: state_nx = S_IF;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  // Trap flag is simply "parked in the halt state"
  assign illegal = (state == S_HALT);
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed scoreboard bench for mips_mc_ctrl
module tb_mips_mc_ctrl;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_OR = 4'd2,
                         A_LUI = 4'd3, A_ADDIU = 4'd4, A_NOR = 4'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       aluout_we, pc_we;
  logic [1:0] pc_src;
  logic       ir_we, mem_re, mem_we, iord, reg_we, reg_dst, mem_to_reg, retire;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;
  exp_t exp_q[$];

  mips_mc_ctrl #(.OP_W(4), .RESET_STATE_IF(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluout_we(aluout_we), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .mem_re(mem_re), .mem_we(mem_we), .iord(iord), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {alu_op, alu_src_a, alu_src_b, aluout_we, pc_we, pc_src, ir_we,
                     mem_re, mem_we, iord, reg_we, reg_dst, mem_to_reg, retire};

  function automatic logic [18:0] mk(input logic [3:0] op, input logic sa, input logic [1:0] sb,
                                     input logic aw, pw, input logic [1:0] ps,
                                     input logic irw, mre, mwe, io, rw, rd, m2r, ret);
    return {op, sa, sb, aw, pw, ps, irw, mre, mwe, io, rw, rd, m2r, ret};
  endfunction

  // Expected output vector per state, written straight from the state table
  function automatic logic [18:0] e_rst();              return mk(A_ADD,0,2'b01,0,0,2'b00,0,1,0,0,0,0,0,0); endfunction
  function automatic logic [18:0] e_if(input logic r);  return mk(A_ADD,0,2'b01,0,r,2'b00,r,1,0,0,0,0,0,0); endfunction
  function automatic logic [18:0] e_id();               return mk(A_ADD,0,2'b11,1,0,2'b00,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [18:0] e_exr(input logic [3:0] o); return mk(o,1,2'b00,1,0,2'b00,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [18:0] e_wbr();              return mk(A_ADD,0,2'b00,0,0,2'b00,0,0,0,0,1,1,0,1); endfunction
  function automatic logic [18:0] e_exi(input logic [3:0] o); return mk(o,1,2'b10,1,0,2'b00,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [18:0] e_wbi();              return mk(A_ADD,0,2'b00,0,0,2'b00,0,0,0,0,1,0,0,1); endfunction
  function automatic logic [18:0] e_addr();             return mk(A_ADD,1,2'b10,1,0,2'b00,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [18:0] e_mrd();              return mk(A_ADD,0,2'b00,0,0,2'b00,0,1,0,1,0,0,0,0); endfunction
  function automatic logic [18:0] e_wbm();              return mk(A_ADD,0,2'b00,0,0,2'b00,0,0,0,0,1,0,1,1); endfunction
  function automatic logic [18:0] e_mwr(input logic r); return mk(A_ADD,0,2'b00,0,0,2'b00,0,0,1,1,0,0,0,r); endfunction
  function automatic logic [18:0] e_br(input logic z);  return mk(A_SUB,1,2'b00,0,z,2'b01,0,0,0,0,0,0,0,1); endfunction
  function automatic logic [18:0] e_j();                return mk(A_ADD,0,2'b00,0,1,2'b10,0,0,0,0,0,0,0,1); endfunction

  task automatic check_front();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  // One clock: drive inputs, push expectation, compare at the falling edge
  task automatic step(input string tag, input logic [18:0] v, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy);
    opcode = op; funct = fn; alu_zero = z; mem_ready = rdy;
    exp_q.push_back('{tag, v});
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    step({tag, "_if"}, e_if(1'b1), op, fn, 1'b0, 1'b1);
    step({tag, "_id"}, e_id(), op, fn, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step("reset_rdy1", e_rst(), 6'd0, 6'd0, 1'b0, 1'b1);
    step("reset_rdy0", e_rst(), 6'd0, 6'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // fetch wait state then addu
    step("if_wait", e_if(1'b0), 6'b000000, 6'b100001, 1'b0, 1'b0);
    fetch_decode("addu", 6'b000000, 6'b100001);
    step("addu_ex", e_exr(A_ADD), 6'b000000, 6'b100001, 1'b0, 1'b1);
    step("addu_wb", e_wbr(), 6'b000000, 6'b100001, 1'b0, 1'b1);

    fetch_decode("subu", 6'b000000, 6'b100011);
    step("subu_ex", e_exr(A_SUB), 6'b000000, 6'b100011, 1'b0, 1'b1);
    step("subu_wb", e_wbr(), 6'b000000, 6'b100011, 1'b0, 1'b1);

    fetch_decode("nor", 6'b000000, 6'b100111);
    step("nor_ex", e_exr(A_NOR), 6'b000000, 6'b100111, 1'b0, 1'b1);
    step("nor_wb", e_wbr(), 6'b000000, 6'b100111, 1'b0, 1'b1);

    // lw with three memory wait states: 8 cycles total
    fetch_decode("lw", 6'b100011, 6'd0);
    step("lw_addr", e_addr(), 6'b100011, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("lw_mrd_wait", e_mrd(), 6'b100011, 6'd0, 1'b0, 1'b0);
    step("lw_mrd_done", e_mrd(), 6'b100011, 6'd0, 1'b0, 1'b1);
    step("lw_wb", e_wbm(), 6'b100011, 6'd0, 1'b0, 1'b1);

    // stray mem_ready outside memory states is ignored
    fetch_decode("beq_t", 6'b000100, 6'd0);
    step("beq_taken", e_br(1'b1), 6'b000100, 6'd0, 1'b1, 1'b1);
    fetch_decode("beq_n", 6'b000100, 6'd0);
    step("beq_not", e_br(1'b0), 6'b000100, 6'd0, 1'b0, 1'b1);

    fetch_decode("lui", 6'b001111, 6'd0);
    step("lui_ex", e_exi(A_LUI), 6'b001111, 6'd0, 1'b0, 1'b1);
    step("lui_wb", e_wbi(), 6'b001111, 6'd0, 1'b0, 1'b1);
    fetch_decode("ori", 6'b001101, 6'd0);
    step("ori_ex", e_exi(A_OR), 6'b001101, 6'd0, 1'b0, 1'b1);
    step("ori_wb", e_wbi(), 6'b001101, 6'd0, 1'b0, 1'b1);
    fetch_decode("addiu", 6'b001001, 6'd0);
    step("addiu_ex", e_exi(A_ADDIU), 6'b001001, 6'd0, 1'b0, 1'b1);
    step("addiu_wb", e_wbi(), 6'b001001, 6'd0, 1'b0, 1'b1);

    fetch_decode("j", 6'b000010, 6'd0);
    step("j_ex", e_j(), 6'b000010, 6'd0, 1'b0, 1'b1);

    // sw, one wait state, normal completion: retire on mem_ready
    fetch_decode("sw", 6'b101011, 6'd0);
    step("sw_addr", e_addr(), 6'b101011, 6'd0, 1'b0, 1'b1);
    step("sw_mwr_wait", e_mwr(1'b0), 6'b101011, 6'd0, 1'b0, 1'b0);
    step("sw_mwr_done", e_mwr(1'b1), 6'b101011, 6'd0, 1'b0, 1'b1);

    // R-type with unknown funct
`ifndef ILLEGAL_TRAP_EN
    fetch_decode("badfn", 6'b000000, 6'b111111);
`endif

    // sw interrupted by reset while waiting on memory
    fetch_decode("swr", 6'b101011, 6'd0);
    step("swr_addr", e_addr(), 6'b101011, 6'd0, 1'b0, 1'b1);
    step("swr_mwr", e_mwr(1'b0), 6'b101011, 6'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    exp_q.push_back('{"swr_rst_now", e_rst()});
    check_front();
    @(posedge clk); #1;
    step("swr_rst_hold", e_rst(), 6'b101011, 6'd0, 1'b0, 1'b1);
    rst = 1'b0;
    step("swr_after", e_if(1'b0), 6'b101011, 6'd0, 1'b0, 1'b0);

    // illegal opcode
    fetch_decode("ill", 6'b111111, 6'd0);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      step("halt", 19'd0, 6'b111111, 6'd0, 1'b1, 1'b1);
      checks++;
      assert (illegal === 1'b1) else begin
        errors++;
        $error("FAIL illegal observed=%b expected=1", illegal);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    assert (illegal === 1'b0) else begin
      errors++;
      $error("FAIL illegal_rst observed=%b expected=0", illegal);
    end
    rst = 1'b0;
`endif
    fetch_decode("tail_j", 6'b000010, 6'd0);
    step("tail_j_ex", e_j(), 6'b000010, 6'd0, 1'b0, 1'b1);
    step("tail_if", e_if(1'b1), 6'b000010, 6'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
